// File: rtl/led_pkg.sv
// ============================================================================
// Module  : led_pkg
// Purpose : Shared types and default timing constants for the smart-LED
//           serial front end (receive state enum, colour word, helpers).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package led_pkg;

  // Default frame geometry and timing, in clk cycles at 50 MHz.
  localparam int DEF_NUM_BITS     = 24;    // G7..G0, R7..R0, B7..B0
  localparam int DEF_T_BIT_THRESH = 30;    // 0.6 us high => logic 1
  localparam int DEF_T_RESET      = 2500;  // 50 us low   => latch gap

  // One pixel's colour word, MSB first on the wire.
  typedef logic [DEF_NUM_BITS-1:0] color_t;

  // Receive state machine encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } led_rx_state_t;

  // Saturating increment used by all pulse-width counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] limit);
    if (value >= limit) begin
      return limit;
    end
    return value + 32'd1;
  endfunction

endpackage : led_pkg

`default_nettype wire

// File: rtl/led_din_sync.sv
// ============================================================================
// Module  : led_din_sync
// Purpose : Two-flop synchronizer for the asynchronous serial input plus a
//           third flop for edge detection. Provides the synchronized level
//           and single-cycle rise/fall strobes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module led_din_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic s,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic meta_d;
  logic sync_q;
  logic sync_d;
  logic dly_q;
  logic dly_d;

  // Next-state for the three-stage shift chain.
  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    dly_d  = sync_q;
  end

  // Synchronizer and edge-detect flops, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign s    = sync_q;
  assign rise = sync_q & ~dly_q;
  assign fall = ~sync_q & dly_q;

endmodule : led_din_sync

`default_nettype wire

// File: rtl/led_din_decoder.sv
// ============================================================================
// Module  : led_din_decoder
// Purpose : Single-wire NRZ (WS2812-style) receiver. Captures the first
//           NUM_BITS bits of a frame into a colour word, regenerates every
//           later bit on dout for the next pixel, and commits the word on
//           the latch gap.
// Options : FRAME_ERR_EN - adds frame_err, a one-cycle pulse on a partial
//           frame at the latch gap or on an over-long high pulse.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module led_din_decoder
  import led_pkg::*;
#(
  parameter int NUM_BITS     = DEF_NUM_BITS,
  parameter int T_BIT_THRESH = DEF_T_BIT_THRESH,
  parameter int T_RESET      = DEF_T_RESET
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                din,
  output logic                dout,
  output logic [NUM_BITS-1:0] color_out,
  output logic                color_valid,
  output logic                busy
`ifdef FRAME_ERR_EN
  ,
  output logic                frame_err
`endif
);

  localparam int HI_W = $clog2(T_BIT_THRESH + 1);
  localparam int LO_W = $clog2(T_RESET + 1);
  localparam int BC_W = $clog2(NUM_BITS + 1);

  localparam logic [HI_W-1:0] HI_MAX   = HI_W'(T_BIT_THRESH);
  localparam logic [LO_W-1:0] LO_MAX   = LO_W'(T_RESET);
  localparam logic [BC_W-1:0] BC_FULL  = BC_W'(NUM_BITS);

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  logic s;
  logic rise;
  logic fall;

  led_din_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din),
    .s     (s),
    .rise  (rise),
    .fall  (fall)
  );

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  led_rx_state_t       state_q,   state_d;
  logic [HI_W-1:0]     hi_cnt_q,  hi_cnt_d;
  logic [LO_W-1:0]     lo_cnt_q,  lo_cnt_d;
  logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [NUM_BITS-1:0] shift_q,   shift_d;
  logic [NUM_BITS-1:0] color_q,   color_d;
  logic                valid_q,   valid_d;
  logic                busy_q,    busy_d;
  logic                fwd_q,     fwd_d;
  logic                dout_q,    dout_d;

  logic [HI_W-1:0]     hi_inc;
  logic [LO_W-1:0]     lo_inc;
  logic                bit_val;
  logic                latch_gap;

`ifdef FRAME_ERR_EN
  // Raw high-time counter that keeps counting past T_BIT_THRESH so that a
  // pulse longer than four bit thresholds can be flagged.
  localparam int LONG_LIM = 4 * T_BIT_THRESH + 1;
  localparam int LONG_W   = $clog2(LONG_LIM + 1);

  logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
  logic [LONG_W-1:0] long_inc;
  logic              err_q,      err_d;
`endif

  // Saturating increments. The rise cycle itself is spent entering HIGH,
  // so at the fall the counter trails the pulse width by one; the
  // incremented value is therefore the true width of the high pulse.
  always_comb begin
    hi_inc  = HI_W'(sat_inc(32'(hi_cnt_q), 32'(T_BIT_THRESH)));
    lo_inc  = LO_W'(sat_inc(32'(lo_cnt_q), 32'(T_RESET)));
    bit_val = (hi_inc >= HI_MAX);
  end

  // Receive FSM next-state, capture shift register and commit logic.
  always_comb begin
    state_d   = state_q;
    hi_cnt_d  = hi_cnt_q;
    lo_cnt_d  = lo_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    color_d   = color_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    latch_gap = 1'b0;

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d  = HIGH;
          hi_cnt_d = '0;
          busy_d   = 1'b1;
        end
      end

      HIGH: begin
        if (fall) begin
          // Only this pixel's own bits are captured; later bits are
          // forwarded and bit_cnt parks at NUM_BITS to mark that.
          if (bit_cnt_q < BC_FULL) begin
            shift_d   = {shift_q[NUM_BITS-2:0], bit_val};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
          state_d  = LOW;
          lo_cnt_d = '0;
        end else begin
          // A stuck-high line simply saturates here; no timeout.
          hi_cnt_d = hi_inc;
        end
      end

      LOW: begin
        lo_cnt_d = lo_inc;
        // The latch gap takes priority over a rise in the same cycle.
        if (lo_inc == LO_MAX) begin
          latch_gap = 1'b1;
          state_d   = IDLE;
          if (bit_cnt_q == BC_FULL) begin
            color_d = shift_q;
            valid_d = 1'b1;
          end
          bit_cnt_d = '0;
          busy_d    = 1'b0;
        end else if (rise) begin
          state_d  = HIGH;
          hi_cnt_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Forward-enable and regenerated output: once the word is full, the
  // synchronized line is copied to dout through one output flop.
  always_comb begin
    fwd_d  = (bit_cnt_d == BC_FULL);
    dout_d = s & fwd_q;
  end

`ifdef FRAME_ERR_EN
  // Long-pulse tracking and frame-error strobe.
  always_comb begin
    long_inc   = LONG_W'(sat_inc(32'(long_cnt_q), 32'(LONG_LIM)));
    long_cnt_d = long_cnt_q;
    err_d      = 1'b0;

    if ((state_q == IDLE && rise) || (state_q == LOW && !latch_gap && rise)) begin
      long_cnt_d = '0;
    end else if (state_q == HIGH) begin
      if (fall) begin
        if ((hi_inc == HI_MAX) && (long_inc > LONG_W'(4 * T_BIT_THRESH))) begin
          err_d = 1'b1;
        end
      end else begin
        long_cnt_d = long_inc;
      end
    end

    if (latch_gap && (bit_cnt_q != '0) && (bit_cnt_q < BC_FULL)) begin
      err_d = 1'b1;
    end
  end

  // Frame-error registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      long_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      long_cnt_q <= long_cnt_d;
      err_q      <= err_d;
    end
  end

  assign frame_err = err_q;
`endif

  // All receive state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hi_cnt_q  <= '0;
      lo_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      color_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      fwd_q     <= 1'b0;
      dout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_cnt_q  <= hi_cnt_d;
      lo_cnt_q  <= lo_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      color_q   <= color_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      fwd_q     <= fwd_d;
      dout_q    <= dout_d;
    end
  end

  assign dout        = dout_q;
  assign color_out   = color_q;
  assign color_valid = valid_q;
  assign busy        = busy_q;

endmodule : led_din_decoder

`default_nettype wire

// File: tb/tb_led_din_decoder.sv
// ============================================================================
// Module  : tb_led_din_decoder
// Purpose : Directed self-checking bench for led_din_decoder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_din_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic        dout;
  logic [23:0] color_out;
  logic        color_valid;
  logic        busy;
`ifdef FRAME_ERR_EN
  logic        frame_err;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  led_din_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .dout        (dout),
    .color_out   (color_out),
    .color_valid (color_valid),
    .busy        (busy)
`ifdef FRAME_ERR_EN
    ,
    .frame_err   (frame_err)
`endif
  );

  // din history: dh[2] is the din value driven three clock edges earlier,
  // which is what dout must show while forwarding is expected.
  logic [2:0] dh = 3'b000;
  logic       fwd_exp = 1'b0;
  int         dout_err = 0;
  int         valid_cnt = 0;
  int         err_cnt = 0;
  int         run_len = 0;
  int         pulse_q[$];

  always @(posedge clk) dh <= {dh[1:0], din};

  always @(negedge clk) begin
    if (color_valid) valid_cnt <= valid_cnt + 1;
`ifdef FRAME_ERR_EN
    if (frame_err) err_cnt <= err_cnt + 1;
`endif
    if (dout !== (dh[2] & fwd_exp)) dout_err <= dout_err + 1;
    if (dout === 1'b1) begin
      run_len <= run_len + 1;
    end else if (run_len > 0) begin
      pulse_q.push_back(run_len);
      run_len <= 0;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached (observed hang, required finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input int high, input int low);
    repeat (high) begin @(posedge clk); #1 din = 1'b1; end
    repeat (low)  begin @(posedge clk); #1 din = 1'b0; end
  endtask

  task automatic send_word(input logic [23:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (w[23-i]) send_bit(40, 22);
      else         send_bit(12, 50);
    end
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
  endtask

  int base_v;
  int base_e;
  int base_p;
  int wmis;
  logic [23:0] w;

  initial begin
    // ---------------- reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_color", 32'(color_out), 32'd0);
    check("rst_valid", 32'(color_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    gap(5);

    // ---------------- frame 0xA5C30F with exact latch timing
    w = 24'hA5C30F;
    for (int i = 0; i < 23; i++) begin
      if (w[23-i]) send_bit(40, 22);
      else         send_bit(12, 50);
    end
    check("f1_busy_mid", 32'(busy), 32'd1);
    send_bit(40, 0);               // last bit is 1; din still high
    @(posedge clk); #1 din = 1'b0;
    repeat (2502) @(posedge clk);
    @(negedge clk);
    check("f1_valid_early", 32'(color_valid), 32'd0);
    check("f1_color_early", 32'(color_out), 32'd0);
    @(posedge clk); @(negedge clk);
    check("f1_valid_at_gap", 32'(color_valid), 32'd1);
    check("f1_color", 32'(color_out), 32'hA5C30F);
    @(posedge clk); @(negedge clk);
    check("f1_valid_after", 32'(color_valid), 32'd0);
    check("f1_busy_after", 32'(busy), 32'd0);
    gap(100);
    check("f1_valid_count", 32'(valid_cnt), 32'd1);
    check("f1_dout_quiet", 32'(pulse_q.size()), 32'd0);
    check("f1_dout_err", 32'(dout_err), 32'd0);

    // ---------------- 48-bit stream: capture first word, forward second
    base_v = valid_cnt;
    send_word(24'h123456, 24);
    @(posedge clk); #1 fwd_exp = 1'b1;
    send_word(24'hFFFF00, 24);
    gap(2600);
    #1 fwd_exp = 1'b0;
    gap(10);
    check("f2_color", 32'(color_out), 32'h123456);
    check("f2_valid_count", 32'(valid_cnt - base_v), 32'd1);
    check("f2_fwd_pulses", 32'(pulse_q.size()), 32'd24);
    wmis = 0;
    for (int i = 0; i < pulse_q.size(); i++) begin
      if (pulse_q[i] != ((i < 16) ? 40 : 12)) wmis++;
    end
    check("f2_fwd_width_mismatches", 32'(wmis), 32'd0);
    if (pulse_q.size() == 24) begin
      check("f2_fwd_first_width", 32'(pulse_q[0]), 32'd40);
      check("f2_fwd_last_width", 32'(pulse_q[23]), 32'd12);
    end
    check("f2_dout_delay3", 32'(dout_err), 32'd0);

    // ---------------- partial frame of 10 bits
    base_v = valid_cnt;
    base_e = err_cnt;
    base_p = pulse_q.size();
    send_word(24'hABCDEF, 10);
    check("f3_busy_mid", 32'(busy), 32'd1);
    gap(2600);
    check("f3_color_kept", 32'(color_out), 32'h123456);
    check("f3_no_valid", 32'(valid_cnt - base_v), 32'd0);
    check("f3_busy_after", 32'(busy), 32'd0);
    check("f3_no_dout", 32'(pulse_q.size() - base_p), 32'd0);
`ifdef FRAME_ERR_EN
    check("f3_frame_err", 32'(err_cnt - base_e), 32'd1);
`endif

    // ---------------- threshold boundary: 29 -> 0, 30 -> 1
    base_v = valid_cnt;
    send_bit(29, 33);
    send_bit(30, 32);
    for (int i = 0; i < 22; i++) send_bit(12, 50);
    gap(2600);
    check("f4_thresh_color", 32'(color_out), 32'h400000);
    check("f4_valid_count", 32'(valid_cnt - base_v), 32'd1);

    // ---------------- 2499-cycle low between bits keeps the frame open
    base_v = valid_cnt;
    w = 24'h0F0F0F;
    for (int i = 0; i < 24; i++) begin
      if (w[23-i]) send_bit(40, (i == 11) ? 2499 : 22);
      else         send_bit(12, (i == 11) ? 2499 : 50);
      if (i == 11) begin
        @(negedge clk);
        check("f5_no_latch_2499", 32'(valid_cnt - base_v), 32'd0);
        check("f5_busy_2499", 32'(busy), 32'd1);
      end
    end
    gap(2600);
    check("f5_color", 32'(color_out), 32'h0F0F0F);
    check("f5_valid_count", 32'(valid_cnt - base_v), 32'd1);

    // ---------------- reset mid-frame, then a clean frame
    send_word(24'h555555, 12);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("f6_rst_color", 32'(color_out), 32'd0);
    check("f6_rst_busy", 32'(busy), 32'd0);
    check("f6_rst_dout", 32'(dout), 32'd0);
    check("f6_rst_valid", 32'(color_valid), 32'd0);
    base_v = valid_cnt;
    send_word(24'h00FF00, 24);
    gap(2600);
    check("f6_color", 32'(color_out), 32'h00FF00);
    check("f6_valid_count", 32'(valid_cnt - base_v), 32'd1);
    check("final_dout_err", 32'(dout_err), 32'd0);
`ifdef FRAME_ERR_EN
    check("final_frame_err_total", 32'(err_cnt), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_led_din_decoder

`default_nettype wire
